mult_io_seq: RTL and testbench



---
 rtl/mult_io_pkg.sv | 15 +
 rtl/braun_array_8x8.sv | 45 ++++
 rtl/mult_io_seq.sv | 78 +++++++
 tb/tb_mult_io_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_io_pkg.sv
// Shared types and widths for the byte-serial multiplier sequencer.
package mult_io_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GOT_A   = 3'd1,
        CALC    = 3'd2,
        SEND_LO = 3'd3,
        SEND_HI = 3'd4
    } state_t;

endpackage

// File: rtl/braun_array_8x8.sv
// Purely combinational unsigned 8x8 Braun multiplier: carry-save rows of full
// adders followed by a ripple adder that resolves the top eight product bits.
module braun_array_8x8
    import mult_io_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [DATA_W:0]   s;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] s_n;
    logic [DATA_W-1:0] c_n;
    logic              pp;
    logic              cy;

    always_comb begin
        // NOTE: every variable gets a default before any loop or branch, so no path can infer a latch.
        s   = '0;
        c   = '0;
        s_n = '0;
        c_n = '0;
        p   = '0;
        pp  = 1'b0;
        cy  = 1'b0;
        // Row i adds partial product a*b[i]; sums shift down one column per row.
        for (int i = 0; i < DATA_W; i++) begin
            for (int j = 0; j < DATA_W; j++) begin
                pp     = a[j] & b[i];
                s_n[j] = pp ^ s[j+1] ^ c[j];
                c_n[j] = (pp & s[j+1]) | (pp & c[j]) | (s[j+1] & c[j]);
            end
            p[i] = s_n[0];
            s    = {1'b0, s_n};
            c    = c_n;
        end
        // Final carry-propagate row; the carry out of bit 15 is always zero.
        for (int k = 0; k < DATA_W; k++) begin
            p[DATA_W+k] = s[k+1] ^ c[k] ^ cy;
            cy          = (s[k+1] & c[k]) | (s[k+1] & cy) | (c[k] & cy);
        end
    end

endmodule

// File: rtl/mult_io_seq.sv
// Collects operands A and B byte-serially, multiplies them through the Braun
// array in one registered stage, and returns the product low byte first.
module mult_io_seq
    import mult_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        op_count
);

    state_t            state;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [PROD_W-1:0] p_r;
    logic [PROD_W-1:0] prod;

    braun_array_8x8 u_braun (
        .a (a_r),
        .b (b_r),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            op_count <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_r   <= in_data;
                    state <= GOT_A;
                end
                GOT_A: if (in_valid) begin
                    b_r   <= in_data;
                    state <= CALC;
                end
                CALC: begin
                    p_r   <= prod;
                    state <= SEND_LO;
                end
                SEND_LO: if (out_ready) state <= SEND_HI;
                SEND_HI: if (out_ready) begin
                    state    <= IDLE;
                    op_count <= op_count + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs decode the state register only; no input reaches them.
    assign in_ready  = (state == IDLE) || (state == GOT_A);
    assign out_valid = (state == SEND_LO) || (state == SEND_HI);
    assign out_last  = (state == SEND_HI);
    assign busy      = (state != IDLE);

    always_comb begin
        out_data = '0;
        if (state == SEND_LO)      out_data = p_r[DATA_W-1:0];
        else if (state == SEND_HI) out_data = p_r[PROD_W-1:DATA_W];
    end

endmodule

// File: tb/tb_mult_io_seq.sv
// Bench for mult_io_seq: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based transaction model.
module tb_mult_io_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mult_io_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: operands gathered so far, a pending product, and the
    // result bytes still owed to the sink.
    logic [7:0]  m_ops[$];
    logic [7:0]  m_out[$];
    logic [15:0] m_prod;
    bit          m_calc = 1'b0;
    logic [7:0]  m_cnt  = 8'd0;
    logic [7:0]  obs[$];

    always @(posedge clk) begin
        if (!rst && !abort && out_valid && out_ready) obs.push_back(out_data);
        if (rst) begin
            m_ops.delete(); m_out.delete(); m_calc = 1'b0; m_cnt = 8'd0;
        end else if (abort) begin
            m_ops.delete(); m_out.delete(); m_calc = 1'b0;
        end else if (m_calc) begin
            m_out.push_back(m_prod[7:0]);
            m_out.push_back(m_prod[15:8]);
            m_calc = 1'b0;
        end else if (m_out.size() > 0) begin
            if (out_ready) begin
                void'(m_out.pop_front());
                if (m_out.size() == 0) m_cnt = m_cnt + 8'd1;
            end
        end else if (in_valid) begin
            m_ops.push_back(in_data);
            if (m_ops.size() == 2) begin
                m_prod = 16'(m_ops[0]) * 16'(m_ops[1]);
                m_calc = 1'b1;
                m_ops.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_in_ready",  {15'd0, in_ready},  {15'd0, (!m_calc && m_out.size() == 0)});
            check("m_out_valid", {15'd0, out_valid}, {15'd0, (m_out.size() > 0)});
            check("m_out_last",  {15'd0, out_last},  {15'd0, (m_out.size() == 1)});
            check("m_out_data",  {8'd0, out_data},   {8'd0, (m_out.size() > 0) ? m_out[0] : 8'h00});
            check("m_busy",      {15'd0, busy},      {15'd0, (m_ops.size() > 0 || m_calc || m_out.size() > 0)});
            check("m_op_count",  {8'd0, op_count},   {8'd0, m_cnt});
        end
    end

    // Presents one byte from a negedge and returns at the negedge after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        logic [7:0] sbytes[4];
        int idx;
        int n0;
        bit took;

        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_in_ready",  {15'd0, in_ready},  16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data",  {8'd0, out_data},   16'h00);
        check("rst_out_last",  {15'd0, out_last},  16'd0);
        check("rst_busy",      {15'd0, busy},      16'd0);
        check("rst_op_count",  {8'd0, op_count},   16'h00);
        rst = 1'b0; in_valid = 1'b0;

        // Basic 0x0D * 0x0B = 0x008F, result two edges after B.
        out_ready = 1'b1;
        send_byte(8'h0D);
        in_valid = 1'b1; in_data = 8'h0B;
        check("basic_b_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("basic_calc_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        check("basic_lo_valid", {15'd0, out_valid}, 16'd1);
        check("basic_lo_data",  {8'd0, out_data},   16'h8F);
        check("basic_lo_last",  {15'd0, out_last},  16'd0);
        @(negedge clk);
        check("basic_hi_data",  {8'd0, out_data},   16'h00);
        check("basic_hi_last",  {15'd0, out_last},  16'd1);
        @(negedge clk);
        check("basic_count", {8'd0, op_count}, 16'd1);
        check("basic_idle",  {15'd0, busy},    16'd0);

        // Max operands under backpressure: 0xFF * 0xFF = 0xFE01.
        out_ready = 1'b0;
        send_byte(8'hFF);
        send_byte(8'hFF);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("max_hold_data", {8'd0, out_data},   16'h01);
            check("max_hold_last", {15'd0, out_last},  16'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("max_lo_data", {8'd0, out_data}, 16'h01);
        @(negedge clk);
        check("max_hi_data", {8'd0, out_data},  16'hFE);
        check("max_hi_last", {15'd0, out_last}, 16'd1);
        @(negedge clk);
        check("max_count", {8'd0, op_count}, 16'd2);

        // Streaming with in_valid held high across two transactions.
        sbytes = '{8'h02, 8'h03, 8'h10, 8'h10};
        n0 = obs.size();
        idx = 0;
        for (int cyc = 0; cyc < 40 && !(idx == 4 && !busy); cyc++) begin
            in_valid = (idx < 4);
            in_data  = (idx < 4) ? sbytes[idx] : 8'h00;
            took     = in_ready && in_valid;
            @(negedge clk);
            if (took) idx++;
        end
        in_valid = 1'b0;
        check("stream_bytes", 16'(obs.size() - n0), 16'd4);
        if (obs.size() >= n0 + 4) begin
            check("stream_b0", {8'd0, obs[n0]},   16'h06);
            check("stream_b1", {8'd0, obs[n0+1]}, 16'h00);
            check("stream_b2", {8'd0, obs[n0+2]}, 16'h00);
            check("stream_b3", {8'd0, obs[n0+3]}, 16'h01);
        end
        check("stream_count", {8'd0, op_count}, 16'd4);

        // Abort coincident with the B byte drops the transaction.
        send_byte(8'h55);
        in_valid = 1'b1; in_data = 8'h77; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy",     {15'd0, busy},     16'd0);
        check("abort_ready",    {15'd0, in_ready}, 16'd1);
        check("abort_count",    {8'd0, op_count},  16'd4);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_idle();
        check("abort_next_lo", {8'd0, obs[obs.size()-2]}, 16'h0C);
        check("abort_next_hi", {8'd0, obs[obs.size()-1]}, 16'h00);
        check("abort_next_count", {8'd0, op_count}, 16'd5);

        // Reset while the high byte of 0x24 * 0x81 = 0x1224 is on the bus.
        out_ready = 1'b0;
        send_byte(8'h24);
        send_byte(8'h81);
        @(negedge clk);
        check("rmid_lo_data", {8'd0, out_data}, 16'h24);
        out_ready = 1'b1;
        @(negedge clk);
        check("rmid_hi_data", {8'd0, out_data},  16'h12);
        check("rmid_hi_last", {15'd0, out_last}, 16'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_valid", {15'd0, out_valid}, 16'd0);
        check("rmid_busy",  {15'd0, busy},      16'd0);
        check("rmid_count", {8'd0, op_count},   16'd0);
        out_ready = 1'b1;
        send_byte(8'h07);
        send_byte(8'h09);
        wait_idle();
        check("rmid_next_lo", {8'd0, obs[obs.size()-2]}, 16'h3F);
        check("rmid_next_hi", {8'd0, obs[obs.size()-1]}, 16'h00);
        check("rmid_next_count", {8'd0, op_count}, 16'd1);

        // Randomized traffic, checked every cycle by the model comparator.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 199) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
        end
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
